// File: rtl/regfile_pkg.sv
// Shared defaults, constants and the write-priority helper for the
// multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int REG_ZERO     = 0;
    localparam int MAX_PORTS    = 8;

    // Highest-index set bit of a port match vector, -1 when none match.
    function automatic int hi_match(logic [MAX_PORTS-1:0] m);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (m[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bundle: read/write ports, stall, scoreboard issue.
// master = pipeline side, slave = register file side.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     stall;
    logic [NUM_RD*AW-1:0]     ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_WR-1:0]        wen;
    logic [NUM_WR*AW-1:0]     wa;
    logic [NUM_WR*DATA_W-1:0] wd;
    logic                     iss_en;
    logic [AW-1:0]            iss_rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        hold_valid;

    modport master (
        output stall, ra, wen, wa, wd, iss_en, iss_rd,
        input  rd, rd_busy, hold_valid
    );

    modport slave (
        input  stall, ra, wen, wa, wd, iss_en, iss_rd,
        output rd, rd_busy, hold_valid
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bits for in-flight destinations; issue sets, array commit clears,
// and a same-cycle set beats the clear.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_rd_i,
    input  logic [NUM_REGS-1:0]  clr_i,
    input  logic [NUM_RD*AW-1:0] ra_i,
    input  logic [NUM_RD-1:0]    hit_i,
    output logic [NUM_RD-1:0]    busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_v;

    always_comb begin
        set_v = '0;
        if (iss_en_i && !(ZERO_R0 != 0 && iss_rd_i == '0)) begin
            set_v[iss_rd_i] = 1'b1;
        end
        busy_d = (busy_q & ~clr_i) | set_v;
    end

    always_ff @(posedge clock) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    always_comb begin
        busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            busy_o[p] = busy_q[ra_i[p*AW +: AW]] & ~hit_i[p];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with per-port stall hold buffers
// and full bypass. Optional busy scoreboard: define REGFILE_SCOREBOARD_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_R0  = 1
) (
    input  logic       clock,
    input  logic       reset,
    regfile_mp_if.slave bus
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    logic [NUM_WR-1:0] hold_vld_q;
    logic [NUM_WR-1:0] hold_vld_d;
    logic [AW-1:0]     hold_addr_q [NUM_WR];
    logic [AW-1:0]     hold_addr_d [NUM_WR];
    logic [DATA_W-1:0] hold_data_q [NUM_WR];
    logic [DATA_W-1:0] hold_data_d [NUM_WR];

    logic [NUM_WR-1:0] eff;
    logic [AW-1:0]     waddr [NUM_WR];
    logic [DATA_W-1:0] wdata [NUM_WR];
    logic [AW-1:0]     raddr [NUM_RD];
    logic [DATA_W-1:0] rdata [NUM_RD];
    logic [NUM_RD-1:0] byp_hit;

    always_comb begin
        eff = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            waddr[w] = bus.wa[w*AW +: AW];
            wdata[w] = bus.wd[w*DATA_W +: DATA_W];
            eff[w]   = bus.wen[w] &&
                       !(ZERO_R0 != 0 && waddr[w] == AW'(REG_ZERO));
        end
        for (int p = 0; p < NUM_RD; p++) begin
            raddr[p] = bus.ra[p*AW +: AW];
        end
    end

    // Hold entries commit first so a younger live write overrides them.
    always_comb begin
        mem_d       = mem_q;
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        if (bus.stall) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (eff[w]) begin
                    hold_vld_d[w]  = 1'b1;
                    hold_addr_d[w] = waddr[w];
                    hold_data_d[w] = wdata[w];
                end
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (hold_vld_q[w]) mem_d[hold_addr_q[w]] = hold_data_q[w];
            end
            for (int w = 0; w < NUM_WR; w++) begin
                if (eff[w]) mem_d[waddr[w]] = wdata[w];
            end
            hold_vld_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
            for (int w = 0; w < NUM_WR; w++) begin
                hold_addr_q[w] <= '0;
                hold_data_q[w] <= '0;
            end
            hold_vld_q <= '0;
        end else begin
            mem_q       <= mem_d;
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    always_comb begin
        logic [MAX_PORTS-1:0] lm;
        logic [MAX_PORTS-1:0] hm;
        int li;
        int hi;
        lm      = '0;
        hm      = '0;
        li      = -1;
        hi      = -1;
        byp_hit = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            lm = '0;
            hm = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                lm[w] = eff[w] && (waddr[w] == raddr[p]);
                hm[w] = hold_vld_q[w] && (hold_addr_q[w] == raddr[p]);
            end
            li = hi_match(lm);
            hi = hi_match(hm);
            rdata[p] = mem_q[raddr[p]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (w == hi) rdata[p] = hold_data_q[w];
            end
            for (int w = 0; w < NUM_WR; w++) begin
                if (w == li) rdata[p] = wdata[w];
            end
            if (ZERO_R0 != 0 && raddr[p] == AW'(REG_ZERO)) rdata[p] = '0;
            byp_hit[p] = (li >= 0) || (hi >= 0);
        end
    end

    always_comb begin
        bus.rd = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd[p*DATA_W +: DATA_W] = rdata[p];
        end
    end

    assign bus.hold_valid = hold_vld_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] clr;

    always_comb begin
        clr = '0;
        if (!bus.stall) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (hold_vld_q[w]) clr[hold_addr_q[w]] = 1'b1;
                if (eff[w])        clr[waddr[w]]       = 1'b1;
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_R0  (ZERO_R0)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .iss_en_i (bus.iss_en),
        .iss_rd_i (bus.iss_rd),
        .clr_i    (clr),
        .ra_i     (bus.ra),
        .hit_i    (byp_hit),
        .busy_o   (bus.rd_busy)
    );
`else
    assign bus.rd_busy = '0;
    wire unused_sb = ^{bus.iss_en, bus.iss_rd, byp_hit};
`endif

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RV32I pipeline; the next generation of the current 2R/1W file.
- Generalises data width, register count, read-port count and write-port count.
- Stalled writebacks go through an explicit per-port hold buffer instead of a delayed-stall flag.
- Bypass covers both live writes and held writes. An optional scoreboard tracks in-flight destinations.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
AW, $clog2(NUM_REGS), register address width (derived, not overridden)
NUM_RD, 2, read ports
NUM_WR, 1, write ports (1..2); higher index has higher priority
ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  pipeline stall; array commits are blocked while high
ra  in  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
rd  out  NUM_RD*DATA_W  read data, combinational
wen  in  NUM_WR  write enables
wa  in  NUM_WR*AW  write addresses
wd  in  NUM_WR*DATA_W  write data
iss_en  in  1  scoreboard: instruction issuing with a destination
iss_rd  in  AW  scoreboard: issuing destination register
rd_busy  out  NUM_RD  scoreboard: read register p has a pending write
hold_valid  out  NUM_WR  hold entry w occupied (debug/perf)

Behaviour:
- Reset, sampled on the rising edge with reset=1:
  - all array entries, hold entries and busy bits are cleared to 0;
  - hold_valid=0 and rd_busy=0 from the next cycle on;
  - reset overrides every simultaneous write, issue or stall.
- A write is effective when wen[w]=1 and not (ZERO_R0 and wa[w]==0).
- Commit with stall=0:
  - each effective write is written to the array at the clock edge;
  - each valid hold entry is also committed in the same cycle;
  - if a live write and a hold entry target the same address, the live write wins (it is younger);
  - if two live ports target the same address, port NUM_WR-1 wins;
  - all hold_valid bits clear.
- Stall=1:
  - no array writes;
  - an effective write on port w loads hold entry w (addr, data) and sets hold_valid[w];
  - an entry that is already valid is overwritten, because a stalled WB re-presents the same write;
  - a valid entry with wen[w]=0 is retained.
- Read data, combinational, priority highest first:
  1. ZERO_R0 and ra==0 -> 0;
  2. live effective write, highest-index port matching ra;
  3. valid hold entry matching ra, highest index;
  4. array.
- The same bypass rules apply during stall, so a stalled reader sees the held value.
- Latency: write-to-read is 0 cycles via bypass; an array commit is visible 1 cycle later.
- Reset mid-stall discards hold contents; a pending held write is lost by design, because the pipeline flushes on reset.
- Out-of-range addresses cannot occur: NUM_REGS is a power of 2.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- With the macro defined:
  - busy[NUM_REGS] register set;
  - iss_en=1 sets busy[iss_rd] at the edge, unless ZERO_R0 and iss_rd==0;
  - an effective array commit clears busy[addr];
  - a hold capture does not clear busy;
  - simultaneous set and clear on the same register -> set wins (new producer);
  - rd_busy[p] = busy[ra[p]] & ~(live effective write matching ra[p]) & ~(valid hold entry matching ra[p]);
  - issue is accepted during stall.
- Without the macro: no busy state; rd_busy tied to 0; iss_en and iss_rd ignored.

Decomposition:
- Shared package/header regfile_pkg.vh holds:
  - DATA_W and NUM_REGS defaults;
  - the REG_ZERO address constant;
  - a write-priority helper function that returns the highest-index matching port.
- One natural sub-module: regfile_scoreboard, holding the busy bits and set/clear logic. It is instantiated only under REGFILE_SCOREBOARD_EN.

Test Plan:
- Reset then read all regs -> rd=0. wen=1, wa=5, wd=0xDEADBEEF, ra0=5 in the same cycle -> rd0=0xDEADBEEF combinationally; rd0 still 0xDEADBEEF next cycle with wen=0.
- Write to r0 with ZERO_R0=1: wa=0, wd=0x1234 -> rd=0 both same cycle and next; hold_valid stays 0 if this happens during stall.
- Stall path:
  - stall=1 for 3 cycles; wa=7, wd=0xAA on each of them -> hold_valid=1 and ra=7 reads 0xAA;
  - stall=0 with wen=1, wa=7, wd=0xBB -> r7=0xBB next cycle and hold_valid=0.
- NUM_WR=2: both ports wa=3, wd0=0x11, wd1=0x22 -> bypass and committed value both 0x22.
- Reset asserted while hold_valid=1 (r9=0x55 held) -> next cycle hold_valid=0 and r9 reads 0.
- Scoreboard (macro on):
  - iss_en with iss_rd=4 -> rd_busy=1 for ra=4;
  - a write to r4 during stall -> rd_busy=0 (hold bypass) but busy remains set;
  - stall drops -> commit clears busy;
  - issue and commit to r4 in the same cycle -> busy stays 1.
